// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bundle between an upstream producer, the serializer and the downstream SISO pins.
interface piso_serializer_if #(
  parameter int unsigned DW = 4
);
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic          hold;
  logic          ser_out;
  logic          ser_enb;
  logic          busy;
  logic          done;

  modport master (
    output din, din_valid, hold,
    input  din_ready, ser_out, ser_enb, busy, done
  );

  modport slave (
    input  din, din_valid, hold,
    output din_ready, ser_out, ser_enb, busy, done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: takes a DW-bit word on a valid/ready handshake
// and emits one qualified bit per cycle for a right-shifting SISO downstream.
module piso_serializer #(
  parameter int unsigned DW        = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  piso_serializer_if.slave  bus
);

  localparam int unsigned CW = $clog2(DW);
  localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state;
  logic [DW-1:0] shreg;
  logic [CW-1:0] cnt;

  logic shifting_c;
  logic last_c;
  logic accept_c;

  // Output decode depends only on registers and hold, never on din_valid.
  assign shifting_c    = (state == SHIFT) && !bus.hold;
  assign last_c        = shifting_c && (cnt == LAST_CNT);
  assign bus.din_ready = (state == IDLE) || last_c;
  assign accept_c      = bus.din_valid && bus.din_ready;

  assign bus.busy    = (state == SHIFT);
  assign bus.ser_enb = shifting_c;
  assign bus.done    = last_c;
  assign bus.ser_out = (state == SHIFT) ? (LSB_FIRST ? shreg[0] : shreg[DW-1]) : 1'b0;

  // A word accepted on the last bit reloads in place, giving zero-bubble back-to-back words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else if (accept_c) begin
      state <= SHIFT;
      shreg <= bus.din;
      cnt   <= '0;
    end else if (shifting_c) begin
      if (last_c) begin
        state <= IDLE;
      end else begin
        shreg <= LSB_FIRST ? {1'b0, shreg[DW-1:1]} : {shreg[DW-2:0], 1'b0};
        cnt   <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: an LSB-first and an MSB-first serializer share stimulus; expected bits are
// queued on accept and compared as qualified bits appear, with a model of the downstream SISO.
module tb_piso_serializer;

  localparam int unsigned DW = 4;

  typedef struct {
    logic          b_l;
    logic          b_m;
    logic          last;
    logic [DW-1:0] word;
  } exp_t;

  logic clk;
  logic rst;

  piso_serializer_if #(.DW(DW)) if_l ();
  piso_serializer_if #(.DW(DW)) if_m ();

  assign if_m.din       = if_l.din;
  assign if_m.din_valid = if_l.din_valid;
  assign if_m.hold      = if_l.hold;

  piso_serializer #(.DW(DW), .LSB_FIRST(1'b1)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (if_l)
  );

  piso_serializer #(.DW(DW), .LSB_FIRST(1'b0)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (if_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  exp_t          sb_q[$];
  logic [DW-1:0] siso;
  int            enb_cnt;
  int            done_cnt;
  int            run_len;
  int            max_run;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue occupancy alone tells whether a word is in flight.
  always @(negedge clk) begin : monitor
    exp_t head;
    logic in_flight, e_enb, e_last, e_ready;
    if (!rst) begin
      sb_q.delete();
      siso    = '0;
      run_len = 0;
    end
    in_flight = (sb_q.size() != 0);
    if (in_flight) head = sb_q[0];
    e_enb   = in_flight && !if_l.hold;
    e_last  = e_enb && head.last;
    e_ready = !in_flight || e_last;

    check_eq("busy_l",  32'(if_l.busy),      32'(in_flight));
    check_eq("busy_m",  32'(if_m.busy),      32'(in_flight));
    check_eq("enb_l",   32'(if_l.ser_enb),   32'(e_enb));
    check_eq("enb_m",   32'(if_m.ser_enb),   32'(e_enb));
    check_eq("done_l",  32'(if_l.done),      32'(e_last));
    check_eq("done_m",  32'(if_m.done),      32'(e_last));
    check_eq("ready_l", 32'(if_l.din_ready), 32'(e_ready));
    check_eq("ready_m", 32'(if_m.din_ready), 32'(e_ready));
    if (!in_flight) begin
      check_eq("idle_ser_l", 32'(if_l.ser_out), 32'(0));
      check_eq("idle_ser_m", 32'(if_m.ser_out), 32'(0));
    end

    if (e_enb) begin
      check_eq("ser_l", 32'(if_l.ser_out), 32'(head.b_l));
      check_eq("ser_m", 32'(if_m.ser_out), 32'(head.b_m));
      siso = {if_l.ser_out, siso[DW-1:1]};
      if (head.last) check_eq("siso_word", 32'(siso), 32'(head.word));
      void'(sb_q.pop_front());
      enb_cnt++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (if_l.done) done_cnt++;

    if (rst && if_l.din_valid && e_ready) begin
      for (int i = 0; i < int'(DW); i++) begin
        exp_t e;
        e.b_l  = if_l.din[i];
        e.b_m  = if_l.din[DW-1-i];
        e.last = (i == int'(DW) - 1);
        e.word = if_l.din;
        sb_q.push_back(e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] w, input bit keep);
    bit ok;
    ok = 1'b0;
    if_l.din       = w;
    if_l.din_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (if_l.din_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!ok) check_eq("accept_timeout", 32'(0), 32'(1));
    if (!keep) if_l.din_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!if_l.busy && !if_m.busy) ok = 1'b1;
    end
    if (!ok) check_eq("idle_timeout", 32'(0), 32'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e0, d0;
    rst            = 1'b0;
    if_l.din       = '0;
    if_l.din_valid = 1'b0;
    if_l.hold      = 1'b0;
    enb_cnt  = 0;
    done_cnt = 0;
    run_len  = 0;
    max_run  = 0;
    siso     = '0;

    // Reset values while held in reset, with valid asserted to show nothing is accepted.
    tick(2);
    if_l.din_valid = 1'b1;
    if_l.din       = 4'hF;
    tick(1);
    check_eq("rst_ready", 32'(if_l.din_ready), 32'(1));
    check_eq("rst_busy",  32'(if_l.busy),      32'(0));
    if_l.din_valid = 1'b0;
    rst = 1'b1;
    tick(2);

    // Single LSB-first word: four qualified bits, one done, SISO ends holding the word.
    e0 = enb_cnt; d0 = done_cnt;
    send_word(4'b1011, 1'b0);
    wait_idle();
    check_eq("t1_enb_count",  32'(enb_cnt - e0),  32'(4));
    check_eq("t1_done_count", 32'(done_cnt - d0), 32'(1));
    check_eq("t1_siso",       32'(siso),          32'(4'b1011));

    // Back-to-back words with valid held: eight contiguous qualified bits.
    max_run = 0; e0 = enb_cnt;
    send_word(4'hA, 1'b1);
    send_word(4'h5, 1'b0);
    wait_idle();
    check_eq("t2_contig", 32'(max_run),       32'(8));
    check_eq("t2_enb",    32'(enb_cnt - e0),  32'(8));
    check_eq("t2_siso",   32'(siso),          32'(4'h5));

    // Hold for three cycles after the second bit.
    e0 = enb_cnt;
    send_word(4'b0110, 1'b0);
    tick(2);
    if_l.hold = 1'b1;
    tick(3);
    if_l.hold = 1'b0;
    wait_idle();
    check_eq("t3_enb", 32'(enb_cnt - e0), 32'(4));

    // MSB-first corner word (checked on the second instance by the scoreboard).
    send_word(4'b1000, 1'b0);
    wait_idle();

    // Reset in the middle of a word: no done pulse, then a clean restart.
    d0 = done_cnt;
    send_word(4'b1100, 1'b0);
    tick(1);
    #2 rst = 1'b0;
    tick(2);
    check_eq("t5_no_done", 32'(done_cnt - d0), 32'(0));
    check_eq("t5_busy",    32'(if_l.busy),     32'(0));
    rst = 1'b1;
    tick(1);
    send_word(4'b1001, 1'b0);
    wait_idle();
    check_eq("t5_siso", 32'(siso), 32'(4'b1001));

    // Valid pulsed during a non-last bit must be ignored.
    e0 = enb_cnt;
    send_word(4'b0011, 1'b0);
    if_l.din       = 4'hF;
    if_l.din_valid = 1'b1;
    @(negedge clk);
    check_eq("t6_ready_l", 32'(if_l.din_ready), 32'(0));
    check_eq("t6_ready_m", 32'(if_m.din_ready), 32'(0));
    @(posedge clk);
    #1;
    if_l.din_valid = 1'b0;
    wait_idle();
    check_eq("t6_enb", 32'(enb_cnt - e0), 32'(4));

    // Random valid, data and hold traffic.
    for (int c = 0; c < 300; c++) begin
      if_l.din_valid = 1'($urandom_range(0, 1));
      if_l.din       = DW'($urandom);
      if_l.hold      = ($urandom_range(0, 3) == 0);
      tick(1);
    end
    if_l.din_valid = 1'b0;
    if_l.hold      = 1'b0;
    wait_idle();
    check_eq("sb_empty", 32'(sb_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
